// File: rtl/weight_stream_loader.sv
// Framed weight-byte loader: turns a valid/ready byte stream into one write per byte
// for the weight register bank and reports frame completion and frame length errors.
module weight_stream_loader #(
   parameter int NUM_WEIGHTS = 30,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clear,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   output logic              load_done,
   output logic              load_err,
   output logic              err_flag,
   output logic [ADDR_W-1:0] idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   idx_reg, idx_next;
   logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
   logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
   logic                wr_en_reg, wr_en_next;
   logic                done_reg, done_next;
   logic                err_reg, err_next;
   logic                err_flag_reg, err_flag_next;
   logic                accept;

   // Reset gates ready directly so the upstream sees backpressure the moment rst rises.
   assign s_ready = en & ~clear & ~rst;
   assign accept  = s_valid & s_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         wr_data_reg  <= '0;
         wr_addr_reg  <= '0;
         wr_en_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_flag_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         wr_data_reg  <= wr_data_next;
         wr_addr_reg  <= wr_addr_next;
         wr_en_reg    <= wr_en_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         err_flag_reg <= err_flag_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      wr_data_next  = wr_data_reg;
      wr_addr_next  = wr_addr_reg;
      wr_en_next    = 1'b0;
      done_next     = 1'b0;
      err_next      = 1'b0;
      err_flag_next = err_flag_reg;

      if (clear) begin
         state_next    = IDLE;
         idx_next      = '0;
         err_flag_next = 1'b0;
      end else if (accept) begin
         case (state_reg)
            IDLE, LOAD: begin
               wr_en_next   = 1'b1;
               wr_addr_next = idx_reg;
               wr_data_next = s_data;
               if (idx_reg == LAST_IDX) begin
                  idx_next = '0;
                  if (s_last) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = DRAIN;
                  end
               end else if (s_last) begin
                  // Short frame: the byte is still written, then the frame is flagged.
                  idx_next      = '0;
                  state_next    = IDLE;
                  err_next      = 1'b1;
                  err_flag_next = 1'b1;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = LOAD;
               end
            end
            DRAIN: begin
               if (s_last) begin
                  state_next    = IDLE;
                  err_next      = 1'b1;
                  err_flag_next = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               idx_next   = '0;
            end
         endcase
      end
   end

   assign wr_data   = wr_data_reg;
   assign wr_addr   = wr_addr_reg;
   assign wr_en     = wr_en_reg;
   assign load_done = done_reg;
   assign load_err  = err_reg;
   assign err_flag  = err_flag_reg;
   assign idx       = idx_reg;

endmodule
